load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the execute datapath and data memory in the RV32I core. It takes the ALU-computed address and register-file read port 2 data (store data), drives a req/ack data-memory bus with byte enables, and returns aligned, sign- or zero-extended load data to register-file write port 3. While an access is outstanding it stalls the core; misaligned accesses, illegal funct3 encodings and bus timeouts are reported as faults.

## Interface
- MAX_WAIT, 255: cycles in REQ without mem_ack before a timeout fault; valid range 1..255; counter is 8 bits.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  current instruction is a load or store
- op_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign field
- addr  in  32  effective byte address (ALU result)
- store_data  in  32  RD2 of register file
- rd  in  5  load destination register
- busy  out  1  stall: hold PC, suppress the core's own register write
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  single-cycle completion strobe
- mem_rdata  in  32  read data, valid with mem_ack
- wb_we  out  1  to WE3
- wb_rd  out  5  to A3
- wb_data  out  32  to WD3
- fault  out  1  one-cycle fault pulse
- fault_addr  out  32  faulting address, held until next fault

## Operation
- States: IDLE, REQ, WB.
- IDLE, op_valid=1, legal and aligned: register addr, funct3, op_store, rd, be, wdata; go to REQ. busy=1 combinationally in this cycle.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- IDLE, illegal or misaligned: fault=1 next cycle, fault_addr=addr; no bus access, no busy, stay IDLE.
- REQ: mem_req=1; all mem_* outputs stable until ack.
- Store + ack: go to IDLE.
- Load + ack: capture extracted data and go to WB.
- REQ without ack: wait counter increments; at MAX_WAIT it pulses fault, sets fault_addr, drops mem_req and returns to IDLE with no writeback.
- WB: wb_we=1 for exactly one cycle (0 if rd=0), busy=0, then IDLE. op_valid is ignored in WB.
- Byte lanes:
  - Byte: be=1<<addr[1:0], wdata={4{store_data[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{store_data[15:0]}}.
  - Word: be=1111.
  - Loads drive the same be with mem_we=0.
- Load extract: lane selected by captured addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (busy, mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_we, wb_rd, wb_data, fault, fault_addr).
- Minimum load: accept cycle, REQ with ack in its first cycle, WB, for 3 cycles with busy high for 2.
- Minimum store: 2 cycles.
- mem_ack in the same cycle as the accept is ignored; only ack in REQ counts.
- mem_ack outside REQ is ignored.
- Reset asserted mid-REQ: mem_req drops immediately; no writeback or fault; a later ack is ignored.
- busy=0 throughout IDLE when op_valid=0 and in WB.

## Structure
- Shared package `lsu_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding, legality/alignment function.
- Sub-module `lsu_load_align`: combinational (mem_rdata, addr[1:0], funct3) → 32-bit extended data.
- The FSM, counter and bus registers live in the top module.

## Test plan
- LW addr=0x100, ack after 2 REQ cycles, rdata=0xDEADBEEF, rd=5: mem_be=1111, mem_we=0; wb_we pulse with wb_rd=5, wb_data=0xDEADBEEF; busy high 3 cycles.
- LB addr=0x203, rdata=0x80FF_0000; LBU on the same address: wb_data=0xFFFF_FF80 for LB, 0x0000_0080 for LBU; mem_be=1000.
- SH addr=0x302, store_data=0x1234ABCD: mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x300; no wb_we.
- LW addr=0x101 and funct3=011: fault pulse, fault_addr=0x101; no mem_req; busy stays 0.
- MAX_WAIT=4, load never acked: mem_req high 4 cycles, then fault=1, return to IDLE, wb_we never set.
- rst low in the 2nd REQ cycle, then ack: mem_req=0 immediately; no wb_we or fault after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the helpers that decide legality, byte enables and store lane replication.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } lsu_state_e;

    // True when the encoding exists for this direction and the address is
    // naturally aligned for the access width.
    function automatic logic op_ok(input logic is_store, input logic [2:0] f3,
                                   input logic [1:0] off);
        logic legal;
        logic aligned;
        legal   = 1'b0;
        aligned = 1'b1;
        case (f3)
            F3_B: legal = 1'b1;
            F3_H: begin
                legal   = 1'b1;
                aligned = ~off[0];
            end
            F3_W: begin
                legal   = 1'b1;
                aligned = (off == 2'b00);
            end
            F3_BU: legal = ~is_store;
            F3_HU: begin
                legal   = ~is_store;
                aligned = ~off[0];
            end
            default: legal = 1'b0;
        endcase
        return legal & aligned;
    endfunction

    // Byte enables for an access; bit 2 of funct3 only selects signedness.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane it could land in, so the
    // byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// according to the load's funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend by width/sign.
    always_comb begin
        shifted = rdata >> {byte_off, 3'b000};
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one access from execute, runs it over
// the req/ack data bus, writes load results back, and reports faults.
// MAX_WAIT must lie in 1..255; the wait counter is 8 bits wide.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        accept;
    logic [31:0] load_data;

    lsu_load_align u_align (
        .rdata    (mem_rdata),
        .byte_off (addr_q[1:0]),
        .funct3   (funct3_q),
        .data     (load_data)
    );

    // A new access is taken only from IDLE and only if it is legal and aligned.
    always_comb begin
        accept = (state_q == ST_IDLE) && op_valid && op_ok(op_store, funct3, addr[1:0]);
    end

    // Next-state logic: accept/fault in IDLE, wait or time out in REQ, one-cycle WB.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        store_d      = store_q;
        rd_d         = rd_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_we_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_REQ;
                    cnt_d       = 8'd0;
                    addr_d      = addr;
                    funct3_d    = funct3;
                    store_d     = op_store;
                    rd_d        = rd;
                    mem_req_d   = 1'b1;
                    mem_we_d    = op_store;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = byte_enable(funct3, addr[1:0]);
                    mem_wdata_d = lane_data(funct3, store_data);
                end else if (op_valid) begin
                    fault_d      = 1'b1;
                    fault_addr_d = addr;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    cnt_d     = 8'd0;
                    if (store_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_WB;
                        wb_we_d   = (rd_q != 5'd0);
                        wb_rd_d   = rd_q;
                        wb_data_d = load_data;
                    end
                end else if (cnt_q == LAST_WAIT) begin
                    state_d      = ST_IDLE;
                    mem_req_d    = 1'b0;
                    cnt_d        = 8'd0;
                    fault_d      = 1'b1;
                    fault_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and every registered output; reset clears all of it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= 32'd0;
            funct3_q     <= 3'd0;
            store_q      <= 1'b0;
            rd_q         <= 5'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            store_q      <= store_d;
            rd_q         <= rd_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Stall while accepting and for every cycle the bus is outstanding.
    always_comb begin
        busy = accept || (state_q == ST_REQ);
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of accesses is driven in a
// loop while a negedge monitor compares bus, writeback and fault events
// against queued expectations; reset and stray-ack cases are hand sequences.
module tb_load_store_unit;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [31:0] fault_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_after;
        logic        early_ack;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    vec_t        vecs[$];
    bus_t        bus_q[$];
    wb_t         wb_q[$];
    logic [31:0] fault_q[$];

    bus_t held;
    logic req_seen = 1'b0;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_store   (op_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every bus request, writeback and fault is matched to the queues.
    always @(negedge clk) begin
        if (!rst) begin
            req_seen = 1'b0;
        end else begin
            if (mem_req && !req_seen) begin
                if (bus_q.size() == 0) begin
                    checkOutput("req_unexpected", {31'd0, mem_req}, 32'd0);
                end else begin
                    held = bus_q.pop_front();
                    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, held.we});
                    checkOutput("mem_addr", mem_addr, held.addr);
                    checkOutput("mem_be", {28'd0, mem_be}, {28'd0, held.be});
                    if (held.chk_wdata)
                        checkOutput("mem_wdata", mem_wdata, held.wdata);
                end
                held.we    = mem_we;
                held.addr  = mem_addr;
                held.be    = mem_be;
                held.wdata = mem_wdata;
            end else if (mem_req) begin
                checkOutput("req_stable_addr", mem_addr, held.addr);
                checkOutput("req_stable_ctl", {27'd0, mem_we, mem_be}, {27'd0, held.we, held.be});
                checkOutput("req_stable_wdata", mem_wdata, held.wdata);
            end
            if (mem_req)
                checkOutput("busy_in_req", {31'd0, busy}, 32'd1);
            req_seen = mem_req;

            if (wb_we) begin
                checkOutput("busy_in_wb", {31'd0, busy}, 32'd0);
                if (wb_q.size() == 0) begin
                    checkOutput("wb_we_unexpected", {31'd0, wb_we}, 32'd0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
                    checkOutput("wb_data", wb_data, w.data);
                end
            end

            if (fault) begin
                if (fault_q.size() == 0) begin
                    checkOutput("fault_unexpected", {31'd0, fault}, 32'd0);
                end else begin
                    logic [31:0] fa;
                    fa = fault_q.pop_front();
                    checkOutput("fault_addr", fault_addr, fa);
                end
            end
        end
    end

    // Drives one table entry, plays the memory side, and checks busy/latency.
    task automatic applyStimulus(input vec_t v);
        int busy_cycles;
        int req_cycles;
        int exp_req;
        bit ok;
        busy_cycles = 0;
        req_cycles  = 0;
        ok          = 1'b0;
        exp_req     = (v.ack_after == 0) ? MAX_WAIT : v.ack_after;

        op_valid   = 1'b1;
        op_store   = v.st;
        funct3     = v.f3;
        addr       = v.addr;
        store_data = v.sdata;
        rd         = v.rd;
        mem_ack    = v.early_ack;
        mem_rdata  = v.early_ack ? 32'hFFFF_FFFF : 32'd0;

        if (v.exp_fault) begin
            fault_q.push_back(v.addr);
        end else begin
            bus_q.push_back('{v.st, {v.addr[31:2], 2'b00}, v.exp_be, v.exp_wdata, v.st});
            if (v.ack_after == 0)
                fault_q.push_back(v.addr);
            else if (!v.st && v.rd != 5'd0)
                wb_q.push_back('{v.rd, v.exp_wb});
        end

        @(negedge clk);
        checkOutput("busy_accept", {31'd0, busy}, {31'd0, ~v.exp_fault});
        if (busy) busy_cycles++;
        @(posedge clk); #1;
        op_valid = 1'b0;
        mem_ack  = 1'b0;

        if (!v.exp_fault) begin
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (busy) busy_cycles++;
                if (!mem_req) begin
                    ok = 1'b1;
                    break;
                end
                req_cycles++;
                mem_ack   = (v.ack_after != 0) && (req_cycles == v.ack_after);
                mem_rdata = v.rdata;
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
            checkOutput("req_done_in_budget", {31'd0, ok}, 32'd1);
            checkOutput("req_cycles", req_cycles, exp_req);
            checkOutput("busy_cycles", busy_cycles, exp_req + 1);
            @(posedge clk); #1;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_req_we_wbwe_fault"}, {28'd0, mem_req, mem_we, wb_we, fault}, 32'd0);
        checkOutput({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        checkOutput({tag, "_wb_data"}, wb_data, 32'd0);
        checkOutput({tag, "_fault_addr"}, fault_addr, 32'd0);
    endtask

    initial begin
        // st f3 addr sdata rd rdata ack_after early_ack exp_fault be wdata wb
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0203, 32'h0, 5'd6, 32'h80FF_0000, 1, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80});
        vecs.push_back('{1'b0, 3'b100, 32'h0000_0203, 32'h0, 5'd7, 32'h80FF_0000, 1, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 5'd0, 32'h0, 1, 1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 32'h0, 1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'b011, 32'h0000_0104, 32'h0, 5'd3, 32'h0, 1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'b001, 32'h0000_0402, 32'h0, 5'd8, 32'h8001_7FFF, 1, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0400, 32'h0, 5'd9, 32'h7FFF_8001, 3, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0000_8001});
        vecs.push_back('{1'b1, 3'b000, 32'h0000_0501, 32'h0000_00A5, 5'd0, 32'h0, 3, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0});
        vecs.push_back('{1'b1, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 5'd0, 32'h0, 1, 1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd0, 32'h1357_9BDF, 1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'b010, 32'h0000_0800, 32'h0, 5'd4, 32'h0, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 3'b001, 32'h0000_0901, 32'h0, 5'd0, 32'h0, 1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 3'b100, 32'h0000_0A00, 32'h0, 5'd0, 32'h0, 1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'b000, 32'h0000_0B00, 32'h0, 5'd9, 32'h0000_0042, 2, 1'b1, 1'b0, 4'b0001, 32'h0, 32'h0000_0042});
        vecs.push_back('{1'b0, 3'b101, 32'h0000_0C03, 32'h0, 5'd2, 32'h0, 1, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Stray ack while idle must not produce any event.
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("idle_ack_no_wb", {31'd0, wb_we}, 32'd0);
        end
        @(posedge clk); #1;

        // Reset in the second REQ cycle of a load, then a late ack.
        op_valid = 1'b1;
        op_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h0000_0D00;
        rd       = 5'd10;
        bus_q.push_back('{1'b0, 32'h0000_0D00, 4'b1111, 32'h0, 1'b0});
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("req_before_rst", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("req_async_drop", {31'd0, mem_req}, 32'd0);
        checkResetState("midreq_rst");
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_rst_quiet", {29'd0, wb_we, fault, mem_req}, 32'd0);
        end

        checkOutput("bus_q_drained", bus_q.size(), 32'd0);
        checkOutput("wb_q_drained", wb_q.size(), 32'd0);
        checkOutput("fault_q_drained", fault_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

endmodule
